alu_multicycle: RTL and testbench
=================================

# alu_multicycle

Parametrised, opcode-decoding ALU for the CPU datapath; successor to the fixed two-phase result unit. Accepts one x86-style operation per `start` on a single clock, decodes the opcode byte `ope[31:24]` (plus ModRM `ope[23:16]` where needed) and produces a WIDTH-bit result, an arithmetic flag vector and a one-cycle `done`. Single-cycle ops complete in one clock; unsigned multiply runs as a WIDTH-step shift-add sequence. Sits between the register file read ports and the writeback/stack-pointer update logic.

## Interface
- WIDTH, 32, datapath width in bits (>= 8)
- STACK_STEP, 4, push/pop/call/ret stack-pointer adjustment
- MUL_EN, 1, 1 = multiply implemented; 0 = opcode 0xf7 reports illegal
- clock  in  1  sole clock, all state on posedge
- reset  in  1  asynchronous, active-high
- start  in  1  request; sampled only in IDLE
- ope  in  32  instruction word; [31:24] opcode, [23:16] ModRM
- immidiate_data  in  WIDTH  immediate operand
- registor_in  in  WIDTH  operand A (destination register / esp)
- registor_in_b  in  WIDTH  operand B (source register)
- busy  out  1  high from accept until done
- done  out  1  one-cycle completion pulse
- illegal  out  1  valid with done; opcode not supported
- alu_result_bus  out  WIDTH  result, held until next completion
- flags  out  4  {OF, SF, ZF, CF}, held until next flag-writing op

## Operation
- States: IDLE, MUL, DONE. IDLE+start: latch ope/operands; single-cycle op -> compute, go DONE; 0xf7 with MUL_EN -> MUL.
- Decode (A = registor_in, B = registor_in_b, I = immidiate_data):
  - 0x55 push, 0xe8 call: A - STACK_STEP; flags kept
  - 0x5d pop, 0xc3 ret: A + STACK_STEP; flags kept
  - 0x89 mov r,r: B; 0xb8 mov imm: I; flags kept
  - 0x01 add, 0x29 sub, 0x21 and, 0x09 or, 0x31 xor: A op B
  - 0x83: A op sext(I[7:0]); op by ModRM reg `ope[21:19]`: 0 add, 1 or, 4 and, 5 sub, 6 xor, 7 cmp (sub, result bus kept, flags written); 2/3 illegal
  - 0xf7 with `ope[21:19]`==4: unsigned A*B, low WIDTH bits to result; other reg values illegal
- Flags: add CF=carry out, sub/cmp CF=borrow; OF=signed overflow; ZF=(result==0); SF=result MSB. and/or/xor: CF=OF=0. mul: CF=OF=(high half != 0), ZF/SF from low half.
- Illegal: done+illegal, result and flags unchanged.
- MUL: WIDTH iterations of shift-add over a 2*WIDTH accumulator, then DONE.
- DONE: assert done one cycle, return IDLE.
- start while busy: ignored, no queueing.

## Timing
- Reset values: busy=0, done=0, illegal=0, alu_result_bus=0, flags=0, state IDLE, accumulator/counter 0.
- Single-cycle op: start at cycle N -> result/flags registered and done=1 at N+1; busy=1 at N+1 only.
- Multiply: start at N -> done at N+WIDTH+1; busy high N+1..N+WIDTH+1.
- Back-to-back: start may be asserted in the cycle done is high; accepted next cycle in IDLE, i.e. max one op per 2 cycles.
- Operands sampled only at accept; later changes have no effect.
- Reset mid-MUL: immediate return to IDLE, all outputs to reset values, no done.
- Wrap-around: push with A < STACK_STEP and pop near 2^WIDTH wrap modulo 2^WIDTH, no flag change.

## Structure
- Package `alu_pkg`: opcode constants (OP_PUSH 8'h55, OP_POP 8'h5d, OP_MOV_RR 8'h89, OP_MOV_IMM 8'hb8, OP_RET 8'hc3, OP_CALL 8'he8, OP_ADD 8'h01, OP_SUB 8'h29, OP_AND 8'h21, OP_OR 8'h09, OP_XOR 8'h31, OP_GRP1 8'h83, OP_GRP3 8'hf7), ModRM reg codes, state encoding, flag bit indices.
- Sub-module `alu_mul_seq`: shift-add multiplier (start, A, B -> done, 2*WIDTH product), instantiated only when MUL_EN=1.

## Test plan
- Reset then push: A=32'h0000_1000 -> result 32'h0000_0FFC, done at +1, flags 0; pop with A=32'hFFFF_FFFE -> 32'h0000_0002 (wrap), flags unchanged.
- add A=32'h7FFF_FFFF, B=1 -> 32'h8000_0000, OF=1 SF=1 ZF=0 CF=0; sub A=0,B=1 -> 32'hFFFF_FFFF, CF=1 SF=1.
- 0x83 ModRM reg=7 (cmp), A=5, I=8'h05 -> ZF=1, result bus retains prior value; reg=0 with I=8'hFF -> A-1.
- mul A=32'h0001_0000, B=32'h0001_0000 -> result 0, CF=OF=1, done exactly 33 cycles after start; start pulses during busy ignored.
- Unknown opcode 8'h00 and 0x83 reg=2 -> done+illegal=1, result/flags unchanged; MUL_EN=0 build: 0xf7 illegal at +1.
- Assert reset at cycle 10 of multiply -> busy/done/result/flags all 0 asynchronously; next start completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode bytes, ModRM reg
// codes, FSM state encoding, decoded operation kinds and flag bit indices.
package alu_pkg;

    localparam int unsigned OPE_W   = 32;
    localparam int unsigned FLAGS_W = 4;

    // Opcode bytes (ope[31:24])
    localparam logic [7:0] OP_PUSH    = 8'h55;
    localparam logic [7:0] OP_POP     = 8'h5d;
    localparam logic [7:0] OP_MOV_RR  = 8'h89;
    localparam logic [7:0] OP_MOV_IMM = 8'hb8;
    localparam logic [7:0] OP_RET     = 8'hc3;
    localparam logic [7:0] OP_CALL    = 8'he8;
    localparam logic [7:0] OP_ADD     = 8'h01;
    localparam logic [7:0] OP_SUB     = 8'h29;
    localparam logic [7:0] OP_AND     = 8'h21;
    localparam logic [7:0] OP_OR      = 8'h09;
    localparam logic [7:0] OP_XOR     = 8'h31;
    localparam logic [7:0] OP_GRP1    = 8'h83;
    localparam logic [7:0] OP_GRP3    = 8'hf7;

    // ModRM reg field (ope[21:19]) selectors
    localparam logic [2:0] REG_ADD = 3'd0;
    localparam logic [2:0] REG_OR  = 3'd1;
    localparam logic [2:0] REG_AND = 3'd4;
    localparam logic [2:0] REG_SUB = 3'd5;
    localparam logic [2:0] REG_XOR = 3'd6;
    localparam logic [2:0] REG_CMP = 3'd7;
    localparam logic [2:0] REG_MUL = 3'd4;

    // Flag vector is {OF, SF, ZF, CF}
    localparam int unsigned FLAG_CF = 0;
    localparam int unsigned FLAG_ZF = 1;
    localparam int unsigned FLAG_SF = 2;
    localparam int unsigned FLAG_OF = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [3:0] {
        K_ILLEGAL, K_DEC, K_INC, K_MOV_B, K_MOV_I,
        K_ADD, K_SUB, K_CMP, K_AND, K_OR, K_XOR, K_MUL
    } alu_kind_e;

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the datapath and the ALU.
// master: drives start, ope, operands; slave (ALU): drives busy, done,
// illegal, alu_result_bus, flags.
interface alu_multicycle_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [31:0]      ope;
    logic [WIDTH-1:0] immidiate_data;
    logic [WIDTH-1:0] registor_in;
    logic [WIDTH-1:0] registor_in_b;
    logic             busy;
    logic             done;
    logic             illegal;
    logic [WIDTH-1:0] alu_result_bus;
    logic [3:0]       flags;

    modport master (
        output start, ope, immidiate_data, registor_in, registor_in_b,
        input  busy, done, illegal, alu_result_bus, flags
    );

    modport slave (
        input  start, ope, immidiate_data, registor_in, registor_in_b,
        output busy, done, illegal, alu_result_bus, flags
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier, one partial product per clock.
// Ports: clock/reset; i_start loads i_a (multiplier) and i_b (multiplicand);
// o_done_c is high during the final step; o_product_c is the accumulator
// value after the current step, so it is the full product when o_done_c=1.
module alu_mul_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_done_c,
    output logic [2*WIDTH-1:0] o_product_c
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_run;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_acc_nx;

    // Add multiplicand to the upper half when the current LSB is set, then shift right
    always_comb begin
        w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
        w_acc_nx = {w_sum, r_acc[WIDTH-1:1]};
    end

    assign o_done_c    = r_run && (r_cnt == CNT_W'(WIDTH - 1));
    assign o_product_c = w_acc_nx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc   <= '0;
            r_mcand <= '0;
            r_cnt   <= '0;
            r_run   <= 1'b0;
        end else if (i_start) begin
            r_acc   <= {WIDTH'(0), i_a};
            r_mcand <= i_b;
            r_cnt   <= '0;
            r_run   <= 1'b1;
        end else if (r_run) begin
            r_acc <= w_acc_nx;
            r_cnt <= r_cnt + CNT_W'(1);
            if (o_done_c) begin
                r_run <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/alu_multicycle.sv
// Opcode-decoding ALU: one op per accepted start, single-cycle ops finish
// next clock, unsigned multiply runs through alu_mul_seq.
// Ports: clock, reset (async, active-high); bus (slave modport) carries
// start/ope/operands in and busy/done/illegal/result/flags out.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned STACK_STEP = 4,
    parameter bit          MUL_EN     = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    alu_multicycle_if.slave bus
);
    state_e             r_state, w_state_nx;
    logic               r_busy, r_done, r_illegal;
    logic [WIDTH-1:0]   r_result;
    logic [3:0]         r_flags;

    logic               w_busy_nx, w_done_nx, w_illegal_nx;
    logic [WIDTH-1:0]   w_result_nx;
    logic [3:0]         w_flags_nx;

    alu_kind_e          w_kind;
    logic [7:0]         w_opcode;
    logic [2:0]         w_reg;
    logic [WIDTH-1:0]   w_a, w_src_b, w_imm_sext, w_res;
    logic [WIDTH:0]     w_sum, w_diff;
    logic               w_cf, w_of, w_wr_res, w_wr_flags;
    logic [3:0]         w_flags;
    logic               w_accept, w_mul_start, w_mul_done;
    logic [2*WIDTH-1:0] w_mul_product;
    logic [3:0]         w_mul_flags;
    logic               w_unused_ope;

    assign w_opcode     = bus.ope[31:24];
    assign w_reg        = bus.ope[21:19];
    assign w_a          = bus.registor_in;
    assign w_imm_sext   = {{(WIDTH-8){bus.immidiate_data[7]}}, bus.immidiate_data[7:0]};
    assign w_unused_ope = ^{bus.ope[23:22], bus.ope[18:0]};
    assign w_accept     = (r_state == ST_IDLE) && bus.start;
    assign w_mul_start  = w_accept && (w_kind == K_MUL);

    // Opcode / ModRM decode
    always_comb begin
        w_kind  = K_ILLEGAL;
        w_src_b = bus.registor_in_b;
        case (w_opcode)
            OP_PUSH, OP_CALL: w_kind = K_DEC;
            OP_POP, OP_RET:   w_kind = K_INC;
            OP_MOV_RR:        w_kind = K_MOV_B;
            OP_MOV_IMM:       w_kind = K_MOV_I;
            OP_ADD:           w_kind = K_ADD;
            OP_SUB:           w_kind = K_SUB;
            OP_AND:           w_kind = K_AND;
            OP_OR:            w_kind = K_OR;
            OP_XOR:           w_kind = K_XOR;
            OP_GRP1: begin
                w_src_b = w_imm_sext;
                case (w_reg)
                    REG_ADD: w_kind = K_ADD;
                    REG_OR:  w_kind = K_OR;
                    REG_AND: w_kind = K_AND;
                    REG_SUB: w_kind = K_SUB;
                    REG_XOR: w_kind = K_XOR;
                    REG_CMP: w_kind = K_CMP;
                    default: w_kind = K_ILLEGAL;
                endcase
            end
            OP_GRP3: begin
                if (MUL_EN && (w_reg == REG_MUL)) begin
                    w_kind = K_MUL;
                end
            end
            default: w_kind = K_ILLEGAL;
        endcase
    end

    // Single-cycle execute; cmp computes the subtraction but only writes flags
    always_comb begin
        w_sum      = {1'b0, w_a} + {1'b0, w_src_b};
        w_diff     = {1'b0, w_a} - {1'b0, w_src_b};
        w_res      = w_a;
        w_cf       = 1'b0;
        w_of       = 1'b0;
        w_wr_res   = 1'b1;
        w_wr_flags = 1'b0;
        case (w_kind)
            K_DEC:   w_res = w_a - WIDTH'(STACK_STEP);
            K_INC:   w_res = w_a + WIDTH'(STACK_STEP);
            K_MOV_B: w_res = bus.registor_in_b;
            K_MOV_I: w_res = bus.immidiate_data;
            K_ADD: begin
                w_res      = w_sum[WIDTH-1:0];
                w_cf       = w_sum[WIDTH];
                w_of       = (w_a[WIDTH-1] == w_src_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
                w_wr_flags = 1'b1;
            end
            K_SUB, K_CMP: begin
                w_res      = w_diff[WIDTH-1:0];
                w_cf       = w_diff[WIDTH];
                w_of       = (w_a[WIDTH-1] != w_src_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
                w_wr_res   = (w_kind == K_SUB);
                w_wr_flags = 1'b1;
            end
            K_AND: begin w_res = w_a & w_src_b; w_wr_flags = 1'b1; end
            K_OR:  begin w_res = w_a | w_src_b; w_wr_flags = 1'b1; end
            K_XOR: begin w_res = w_a ^ w_src_b; w_wr_flags = 1'b1; end
            default: w_wr_res = 1'b0;
        endcase
        w_flags          = '0;
        w_flags[FLAG_CF] = w_cf;
        w_flags[FLAG_ZF] = (w_res == '0);
        w_flags[FLAG_SF] = w_res[WIDTH-1];
        w_flags[FLAG_OF] = w_of;
    end

    generate
        if (MUL_EN) begin : g_mul
            alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
                .clock       (clock),
                .reset       (reset),
                .i_start     (w_mul_start),
                .i_a         (bus.registor_in),
                .i_b         (bus.registor_in_b),
                .o_done_c    (w_mul_done),
                .o_product_c (w_mul_product)
            );
        end else begin : g_no_mul
            assign w_mul_done    = 1'b0;
            assign w_mul_product = '0;
        end
    endgenerate

    // Multiply flags: CF/OF report a non-zero high half
    always_comb begin
        w_mul_flags          = '0;
        w_mul_flags[FLAG_CF] = (w_mul_product[2*WIDTH-1:WIDTH] != '0);
        w_mul_flags[FLAG_OF] = (w_mul_product[2*WIDTH-1:WIDTH] != '0);
        w_mul_flags[FLAG_ZF] = (w_mul_product[WIDTH-1:0] == '0);
        w_mul_flags[FLAG_SF] = w_mul_product[WIDTH-1];
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_state_nx = (w_kind == K_MUL) ? ST_MUL : ST_DONE;
            ST_MUL:  if (w_mul_done) w_state_nx = ST_DONE;
            ST_DONE: w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Output next-values, registered below so every output comes from a flop
    always_comb begin
        w_busy_nx    = (w_state_nx != ST_IDLE);
        w_done_nx    = (w_state_nx == ST_DONE);
        w_illegal_nx = 1'b0;
        w_result_nx  = r_result;
        w_flags_nx   = r_flags;
        if (w_accept && (w_kind != K_MUL)) begin
            w_illegal_nx = (w_kind == K_ILLEGAL);
            if (w_wr_res)   w_result_nx = w_res;
            if (w_wr_flags) w_flags_nx  = w_flags;
        end
        if ((r_state == ST_MUL) && w_mul_done) begin
            w_result_nx = w_mul_product[WIDTH-1:0];
            w_flags_nx  = w_mul_flags;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_result  <= '0;
            r_flags   <= '0;
        end else begin
            r_busy    <= w_busy_nx;
            r_done    <= w_done_nx;
            r_illegal <= w_illegal_nx;
            r_result  <= w_result_nx;
            r_flags   <= w_flags_nx;
        end
    end

    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.illegal        = r_illegal;
    assign bus.alu_result_bus = r_result;
    assign bus.flags          = r_flags;
endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed vector table, hand-written
// multi-cycle sequences, a MUL_EN=0 build, and randomized ops against a
// plain-arithmetic reference model.
module tb_alu_multicycle;
    localparam int unsigned W    = 32;
    localparam int unsigned STEP = 4;
    localparam longint     SMAX = 64'sd2147483647;
    localparam longint     SMIN = -64'sd2147483648;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [W-1:0] m_res;
    logic [3:0]   m_flags;

    alu_multicycle_if #(.WIDTH(W)) bus_if ();
    alu_multicycle_if #(.WIDTH(W)) bus0 ();

    alu_multicycle #(.WIDTH(W), .STACK_STEP(STEP), .MUL_EN(1'b1)) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    alu_multicycle #(.WIDTH(W), .STACK_STEP(STEP), .MUL_EN(1'b0)) dut_nomul (
        .clock (clk),
        .reset (reset),
        .bus   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ope;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] x_res;
        logic [3:0]  x_flags;
        logic        x_ill;
        int          x_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic add_vec(input logic [31:0] ope, a, b, imm, x_res,
                           input logic [3:0] x_flags, input logic x_ill, input int x_lat);
        vec_t v;
        v = '{ope, a, b, imm, x_res, x_flags, x_ill, x_lat};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [31:0] ope, a, b, imm);
        bus_if.ope            = ope;
        bus_if.registor_in    = a;
        bus_if.registor_in_b  = b;
        bus_if.immidiate_data = imm;
    endtask

    // Issue one op with a single-cycle start pulse; lat = clocks from accept edge to done
    task automatic run_op(input logic [31:0] ope, a, b, imm, output int lat);
        @(posedge clk); #1;
        drive(ope, a, b, imm);
        bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        lat = 1;
        while (!bus_if.done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_op(input string tag, input logic [31:0] ope, a, b, imm,
                            input logic [31:0] x_res, input logic [3:0] x_fl,
                            input logic x_ill, input int x_lat);
        int lat;
        run_op(ope, a, b, imm, lat);
        chk({tag, "_lat"},     64'(lat), 64'(x_lat));
        chk({tag, "_res"},     bus_if.alu_result_bus, x_res);
        chk({tag, "_flags"},   bus_if.flags, x_fl);
        chk({tag, "_illegal"}, bus_if.illegal, x_ill);
        chk({tag, "_busy"},    bus_if.busy, 1'b1);
    endtask

    // Reference model: ISA-level behaviour in 64-bit integer arithmetic
    task automatic model_step(input logic [31:0] ope, a, b, imm,
                              output logic [31:0] e_res, output logic [3:0] e_flags,
                              output logic e_ill, output int e_lat);
        logic [7:0]      opc;
        logic [2:0]      rg;
        logic [31:0]     y, r;
        int              kind, t;
        longint unsigned ux, uy, s;
        longint          sx, sy, ss;
        logic            cf, of, wr_res, wr_fl;
        opc = ope[31:24];
        rg  = ope[21:19];
        y = b; r = '0; kind = 0; cf = 1'b0; of = 1'b0;
        wr_res = 1'b0; wr_fl = 1'b0; e_ill = 1'b0; e_lat = 1;
        case (opc)
            8'h55, 8'he8: begin r = a - STEP; wr_res = 1'b1; end
            8'h5d, 8'hc3: begin r = a + STEP; wr_res = 1'b1; end
            8'h89: begin r = b; wr_res = 1'b1; end
            8'hb8: begin r = imm; wr_res = 1'b1; end
            8'h01: kind = 1;
            8'h29: kind = 2;
            8'h21: kind = 3;
            8'h09: kind = 4;
            8'h31: kind = 5;
            8'h83: begin
                t = $signed(imm[7:0]);
                y = t;
                case (rg)
                    3'd0: kind = 1;
                    3'd1: kind = 4;
                    3'd4: kind = 3;
                    3'd5: kind = 2;
                    3'd6: kind = 5;
                    3'd7: kind = 6;
                    default: e_ill = 1'b1;
                endcase
            end
            8'hf7: begin
                if (rg == 3'd4) begin
                    ux = a; uy = b; s = ux * uy;
                    r = s[31:0];
                    cf = (s[63:32] != 0); of = cf;
                    wr_res = 1'b1; wr_fl = 1'b1;
                    e_lat = W + 1;
                end else begin
                    e_ill = 1'b1;
                end
            end
            default: e_ill = 1'b1;
        endcase
        if (kind != 0) begin
            ux = a; uy = y; sx = $signed(a); sy = $signed(y);
            case (kind)
                1: begin s = ux + uy; r = s[31:0]; cf = s[32]; ss = sx + sy; of = (ss > SMAX) || (ss < SMIN); end
                2, 6: begin s = ux - uy; r = s[31:0]; cf = (ux < uy); ss = sx - sy; of = (ss > SMAX) || (ss < SMIN); end
                3: r = a & y;
                4: r = a | y;
                default: r = a ^ y;
            endcase
            wr_fl = 1'b1;
            wr_res = (kind != 6);
        end
        e_res   = wr_res ? r : m_res;
        e_flags = wr_fl ? {of, r[31], (r == 0), cf} : m_flags;
        m_res   = e_res;
        m_flags = e_flags;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    logic [7:0] op_list[14] = '{8'h55, 8'h5d, 8'h89, 8'hb8, 8'hc3, 8'he8, 8'h01,
                                8'h29, 8'h21, 8'h09, 8'h31, 8'h83, 8'hf7, 8'h00};

    initial begin
        logic [31:0] er, ope;
        logic [3:0]  ef;
        logic        ei;
        int          el, lat;
        logic [2:0]  rg;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus_if.start = 1'b0;
        drive('0, '0, '0, '0);
        bus0.start = 1'b0; bus0.ope = '0; bus0.registor_in = '0;
        bus0.registor_in_b = '0; bus0.immidiate_data = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",    bus_if.busy, 1'b0);
        chk("rst_done",    bus_if.done, 1'b0);
        chk("rst_illegal", bus_if.illegal, 1'b0);
        chk("rst_result",  bus_if.alu_result_bus, 32'h0);
        chk("rst_flags",   bus_if.flags, 4'h0);
        reset = 1'b0;
        m_res = '0;
        m_flags = '0;

        // Directed vectors; each row depends on the result/flags left by the previous one
        add_vec(32'h5500_0000, 32'h0000_1000, 0, 0, 32'h0000_0FFC, 4'h0, 0, 1);
        add_vec(32'h5d00_0000, 32'hFFFF_FFFE, 0, 0, 32'h0000_0002, 4'h0, 0, 1);
        add_vec(32'h0100_0000, 32'h7FFF_FFFF, 1, 0, 32'h8000_0000, 4'hC, 0, 1);
        add_vec(32'h5500_0000, 32'h0000_0002, 0, 0, 32'hFFFF_FFFE, 4'hC, 0, 1);
        add_vec(32'h2900_0000, 32'h0, 1, 0, 32'hFFFF_FFFF, 4'h5, 0, 1);
        add_vec(32'h8338_0000, 32'h5, 0, 32'h05, 32'hFFFF_FFFF, 4'h2, 0, 1);
        add_vec(32'h8300_0000, 32'hA, 0, 32'hFF, 32'h0000_0009, 4'h1, 0, 1);
        add_vec(32'h0000_0000, 32'h1, 2, 3, 32'h0000_0009, 4'h1, 1, 1);
        add_vec(32'h8310_0000, 32'h1, 2, 3, 32'h0000_0009, 4'h1, 1, 1);
        add_vec(32'h2100_0000, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 0, 32'h0, 4'h2, 0, 1);
        add_vec(32'h0900_0000, 32'h8000_0000, 1, 0, 32'h8000_0001, 4'h4, 0, 1);
        add_vec(32'h3100_0000, 32'h1234, 32'h1234, 0, 32'h0, 4'h2, 0, 1);
        add_vec(32'h8900_0000, 32'h1, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 4'h2, 0, 1);
        add_vec(32'hb800_0000, 32'h1, 2, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'h2, 0, 1);
        add_vec(32'he800_0000, 32'h0, 0, 0, 32'hFFFF_FFFC, 4'h2, 0, 1);
        add_vec(32'hc300_0000, 32'hFFFF_FFFE, 0, 0, 32'h0000_0002, 4'h2, 0, 1);
        add_vec(32'h2900_0000, 32'h8000_0000, 1, 0, 32'h7FFF_FFFF, 4'h8, 0, 1);
        add_vec(32'hF7E0_0000, 32'h0001_0000, 32'h0001_0000, 0, 32'h0, 4'hB, 0, 33);
        add_vec(32'hF7E0_0000, 32'h3, 32'h5, 0, 32'hF, 4'h0, 0, 33);
        add_vec(32'hF718_0000, 32'h3, 32'h5, 0, 32'hF, 4'h0, 1, 1);
        add_vec(32'h8328_0000, 32'h0, 0, 32'h80, 32'h0000_0080, 4'h1, 0, 1);
        add_vec(32'h8308_0000, 32'h100, 0, 32'h7F, 32'h0000_017F, 4'h0, 0, 1);
        add_vec(32'h8320_0000, 32'hFFFF, 0, 32'h80, 32'h0000_FF80, 4'h0, 0, 1);
        add_vec(32'h8330_0000, 32'h0, 0, 32'h81, 32'hFFFF_FF81, 4'h4, 0, 1);

        foreach (vecs[i]) begin
            model_step(vecs[i].ope, vecs[i].a, vecs[i].b, vecs[i].imm, er, ef, ei, el);
            check_op($sformatf("vec%0d", i), vecs[i].ope, vecs[i].a, vecs[i].b, vecs[i].imm,
                     vecs[i].x_res, vecs[i].x_flags, vecs[i].x_ill, vecs[i].x_lat);
        end

        // Multiply with start toggling and operands changing while busy
        @(posedge clk); #1;
        drive(32'hF7E0_0000, 32'd7, 32'd9, 0);
        bus_if.start = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        chk("mulbusy_busy", bus_if.busy, 1'b1);
        drive(32'h0100_0000, 32'd1, 32'd1, 0);
        while (!bus_if.done && lat < 100) begin
            bus_if.start = ~bus_if.start;
            @(posedge clk); #1;
            lat++;
        end
        bus_if.start = 1'b0;
        model_step(32'hF7E0_0000, 32'd7, 32'd9, 0, er, ef, ei, el);
        chk("mulbusy_lat",   64'(lat), 64'(el));
        chk("mulbusy_res",   bus_if.alu_result_bus, er);
        chk("mulbusy_flags", bus_if.flags, ef);
        @(posedge clk); #1;
        chk("mulbusy_nodone", bus_if.done, 1'b0);
        chk("mulbusy_idle",   bus_if.busy, 1'b0);

        // Back-to-back: start held high yields one op every two cycles
        @(posedge clk); #1;
        drive(32'h2900_0000, 32'd1, 32'd2, 0);
        bus_if.start = 1'b1;
        @(posedge clk); #1;
        chk("b2b_done1", bus_if.done, 1'b1);
        @(posedge clk); #1;
        chk("b2b_gap_done", bus_if.done, 1'b0);
        chk("b2b_gap_busy", bus_if.busy, 1'b0);
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        chk("b2b_done2", bus_if.done, 1'b1);
        model_step(32'h2900_0000, 32'd1, 32'd2, 0, er, ef, ei, el);
        model_step(32'h2900_0000, 32'd1, 32'd2, 0, er, ef, ei, el);
        chk("b2b_res",   bus_if.alu_result_bus, er);
        chk("b2b_flags", bus_if.flags, ef);
        @(posedge clk); #1;
        chk("b2b_after", bus_if.done, 1'b0);

        // Asynchronous reset in cycle 10 of a multiply
        @(posedge clk); #1;
        drive(32'hF7E0_0000, 32'h0001_0000, 32'h0001_0000, 0);
        bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("rstmul_busy",    bus_if.busy, 1'b0);
        chk("rstmul_done",    bus_if.done, 1'b0);
        chk("rstmul_illegal", bus_if.illegal, 1'b0);
        chk("rstmul_result",  bus_if.alu_result_bus, 32'h0);
        chk("rstmul_flags",   bus_if.flags, 4'h0);
        @(posedge clk); #1;
        chk("rstmul_hold_done", bus_if.done, 1'b0);
        reset = 1'b0;
        m_res = '0;
        m_flags = '0;
        model_step(32'h0100_0000, 32'd2, 32'd3, 0, er, ef, ei, el);
        check_op("post_rst", 32'h0100_0000, 32'd2, 32'd3, 0, er, ef, ei, el);
        model_step(32'hF7E0_0000, 32'h0001_0000, 32'h0001_0000, 0, er, ef, ei, el);
        check_op("post_rst_mul", 32'hF7E0_0000, 32'h0001_0000, 32'h0001_0000, 0, er, ef, ei, el);

        // Build without multiplier: 0xf7 is illegal after one cycle
        @(posedge clk); #1;
        bus0.ope = 32'hF7E0_0000; bus0.registor_in = 32'd3; bus0.registor_in_b = 32'd5;
        bus0.start = 1'b1;
        @(posedge clk); #1;
        bus0.start = 1'b0;
        chk("nomul_done",    bus0.done, 1'b1);
        chk("nomul_illegal", bus0.illegal, 1'b1);
        chk("nomul_result",  bus0.alu_result_bus, 32'h0);
        chk("nomul_flags",   bus0.flags, 4'h0);

        // Randomized ops against the reference model
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a, b, imm;
            ope = {op_list[$urandom_range(0, 13)], 24'($urandom)};
            if ($urandom_range(0, 9) == 0) ope[31:24] = 8'($urandom);
            if (ope[31:24] == 8'hf7) begin
                rg = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd4;
                ope[21:19] = rg;
            end
            a = rnd_val(); b = rnd_val(); imm = rnd_val();
            model_step(ope, a, b, imm, er, ef, ei, el);
            check_op($sformatf("rnd%0d", n), ope, a, b, imm, er, ef, ei, el);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
